// File: rtl/icache_fill_responder_if.sv
// Bundle of icache miss/fill, L2 read and invalidate channels for icache_fill_responder.
// slave: the responder's view; master: the environment (icache + L2) view.
interface icache_fill_responder_if #(
  parameter int PA29_WIDTH = 29,
  parameter int PA28_WIDTH = 28
);
  logic                  req_valid;
  logic                  req_ready;
  logic [PA29_WIDTH-1:0] req_PA29;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [PA28_WIDTH-1:0] mem_req_PA28;
  logic                  mem_resp_valid;
  logic [PA28_WIDTH-1:0] mem_resp_PA28;
  logic [511:0]          mem_resp_data512;
  logic                  inv_valid;
  logic [PA28_WIDTH-1:0] inv_PA28;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [PA29_WIDTH-1:0] resp_PA29;
  logic [255:0]          resp_data256;
  logic                  resp_err;

  modport slave (
    input  req_valid, req_PA29, mem_req_ready, mem_resp_valid, mem_resp_PA28,
           mem_resp_data512, inv_valid, inv_PA28, resp_ready,
    output req_ready, mem_req_valid, mem_req_PA28, resp_valid, resp_PA29,
           resp_data256, resp_err
  );

  modport master (
    output req_valid, req_PA29, mem_req_ready, mem_resp_valid, mem_resp_PA28,
           mem_resp_data512, inv_valid, inv_PA28, resp_ready,
    input  req_ready, mem_req_valid, mem_req_PA28, resp_valid, resp_PA29,
           resp_data256, resp_err
  );
endinterface

// File: rtl/icache_fill_responder.sv
// Queues icache misses, reads 64B blocks from L2 one at a time, returns the demanded 32B half.
// Define ICACHE_FILL_SIBLING_PUSH_EN to also push the sibling half as an unsolicited fill.
module icache_fill_responder #(
  parameter int REQ_FIFO_DEPTH = 4,
  parameter int PA29_WIDTH     = 29,
  parameter int PA28_WIDTH     = 28
) (
  input logic CLK,
  input logic RST,
  icache_fill_responder_if.slave bus
);
  localparam int PTR_W = $clog2(REQ_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(REQ_FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MEM_REQ = 3'd1,
    WAIT    = 3'd2,
    SEND    = 3'd3,
    SIBLING = 3'd4
  } state_t;

  function automatic logic [255:0] select_half(input logic [511:0] data, input logic upper);
    return upper ? data[511:256] : data[255:0];
  endfunction

  logic [PA29_WIDTH-1:0] fifo_mem_r [REQ_FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic [CNT_W-1:0]      count_next_s;
  logic                  req_ready_r;
  logic                  push_s;
  logic                  pop_s;

  logic [PA29_WIDTH-1:0] head_pa29_s;
  logic [PA28_WIDTH-1:0] head_pa28_s;
  logic                  head_upper_s;
  logic                  head_buf_hit_s;
  logic                  inv_buf_s;
  logic                  inv_head_s;

  state_t                state_r;
  logic                  mem_req_valid_r;
  logic [PA28_WIDTH-1:0] mem_req_pa28_r;
  logic                  resp_valid_r;
  logic [PA29_WIDTH-1:0] resp_pa29_r;
  logic [255:0]          resp_data_r;
  logic                  resp_err_r;
  logic                  buf_valid_r;
  logic [PA28_WIDTH-1:0] buf_pa28_r;
  logic [511:0]          buf_data_r;
  logic                  kill_r;

  assign push_s         = bus.req_valid && req_ready_r;
  assign pop_s          = (state_r == SEND) && bus.resp_ready;
  assign count_next_s   = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
  assign head_pa29_s    = fifo_mem_r[rd_ptr_r];
  assign head_pa28_s    = head_pa29_s[PA29_WIDTH-1:1];
  assign head_upper_s   = head_pa29_s[0];
  assign head_buf_hit_s = buf_valid_r && (buf_pa28_r == head_pa28_s);
  assign inv_buf_s      = bus.inv_valid && (bus.inv_PA28 == buf_pa28_r);
  assign inv_head_s     = bus.inv_valid && (bus.inv_PA28 == head_pa28_s);

  assign bus.req_ready     = req_ready_r;
  assign bus.mem_req_valid = mem_req_valid_r;
  assign bus.mem_req_PA28  = mem_req_pa28_r;
  assign bus.resp_valid    = resp_valid_r;
  assign bus.resp_PA29     = resp_pa29_r;
  assign bus.resp_data256  = resp_data_r;
  assign bus.resp_err      = resp_err_r;

  // Request queue; req_ready is registered from the next occupancy so it reads 0 under reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= CNT_ZERO;
      req_ready_r <= 1'b0;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= bus.req_PA29;
        wr_ptr_r             <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r     <= count_next_s;
      req_ready_r <= (count_next_s != CNT_FULL);
    end
  end

  // Fill FSM with block buffer; every output is loaded on the edge that enters its state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r         <= IDLE;
      mem_req_valid_r <= 1'b0;
      mem_req_pa28_r  <= {PA28_WIDTH{1'b0}};
      resp_valid_r    <= 1'b0;
      resp_pa29_r     <= {PA29_WIDTH{1'b0}};
      resp_data_r     <= 256'h0;
      resp_err_r      <= 1'b0;
      buf_valid_r     <= 1'b0;
      buf_pa28_r      <= {PA28_WIDTH{1'b0}};
      buf_data_r      <= 512'h0;
      kill_r          <= 1'b0;
    end else begin
      if (inv_buf_s) begin
        buf_valid_r <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (count_r != CNT_ZERO) begin
            if (head_buf_hit_s) begin
              state_r      <= SEND;
              resp_valid_r <= 1'b1;
              resp_pa29_r  <= head_pa29_s;
              resp_data_r  <= select_half(buf_data_r, head_upper_s);
            end else begin
              state_r         <= MEM_REQ;
              mem_req_valid_r <= 1'b1;
              mem_req_pa28_r  <= head_pa28_s;
              kill_r          <= 1'b0;
            end
          end
        end
        MEM_REQ: begin
          if (bus.mem_req_ready) begin
            state_r         <= WAIT;
            mem_req_valid_r <= 1'b0;
          end
        end
        WAIT: begin
          if (bus.mem_resp_valid && (bus.mem_resp_PA28 == head_pa28_s)) begin
            // An invalidate seen while waiting still lets this fill through but leaves the buffer cold.
            buf_valid_r  <= !(kill_r || inv_head_s);
            buf_pa28_r   <= bus.mem_resp_PA28;
            buf_data_r   <= bus.mem_resp_data512;
            state_r      <= SEND;
            resp_valid_r <= 1'b1;
            resp_pa29_r  <= head_pa29_s;
            resp_data_r  <= select_half(bus.mem_resp_data512, head_upper_s);
          end else if (bus.mem_resp_valid) begin
            resp_err_r <= 1'b1;
          end else if (inv_head_s) begin
            kill_r <= 1'b1;
          end
        end
        SEND: begin
          if (bus.resp_ready) begin
`ifdef ICACHE_FILL_SIBLING_PUSH_EN
            if (head_buf_hit_s && !inv_buf_s) begin
              state_r     <= SIBLING;
              resp_pa29_r <= {head_pa28_s, ~head_upper_s};
              resp_data_r <= select_half(buf_data_r, ~head_upper_s);
            end else begin
              state_r      <= IDLE;
              resp_valid_r <= 1'b0;
            end
`else
            state_r      <= IDLE;
            resp_valid_r <= 1'b0;
`endif
          end
        end
        SIBLING: begin
          if (bus.resp_ready) begin
            state_r      <= IDLE;
            resp_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r         <= IDLE;
          mem_req_valid_r <= 1'b0;
          resp_valid_r    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_icache_fill_responder.sv
// Table-driven cycle-by-cycle bench for icache_fill_responder plus a hand-written latency sequence.
// Expected fills follow ICACHE_FILL_SIBLING_PUSH_EN when the bench is built with it.
module tb_icache_fill_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  icache_fill_responder_if bus ();

  icache_fill_responder dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] mkdata(input logic [27:0] pa28);
    logic [511:0] d;
    for (int w = 0; w < 16; w++) d[w*32 +: 32] = {pa28, 4'(w)};
    return d;
  endfunction

  function automatic logic [255:0] exp_half(input logic [28:0] pa29);
    logic [511:0] d;
    d = mkdata(pa29[28:1]);
    return pa29[0] ? d[511:256] : d[255:0];
  endfunction

  assign bus.mem_resp_data512 = mkdata(bus.mem_resp_PA28);

  typedef struct {
    logic        rst;
    logic        rq;
    logic [28:0] rpa;
    logic        mrdy;
    logic        mrv;
    logic [27:0] mrpa;
    logic        iv;
    logic [27:0] ipa;
    logic        rrdy;
    logic        e_rr;
    logic        e_mv;
    logic [27:0] e_mpa;
    logic        e_rv;
    logic [28:0] e_rpa;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  localparam logic        O   = 1'b0;
  localparam logic        I   = 1'b1;
  localparam logic [28:0] Z29 = 29'h0;
  localparam logic [27:0] Z28 = 28'h0;

  task automatic add(input logic r, input logic rq, input logic [28:0] rpa, input logic mrdy,
                     input logic mrv, input logic [27:0] mrpa, input logic iv, input logic [27:0] ipa,
                     input logic rrdy, input logic e_rr, input logic e_mv, input logic [27:0] e_mpa,
                     input logic e_rv, input logic [28:0] e_rpa, input logic e_err);
    vec_t v;
    v.rst = r; v.rq = rq; v.rpa = rpa; v.mrdy = mrdy; v.mrv = mrv; v.mrpa = mrpa;
    v.iv = iv; v.ipa = ipa; v.rrdy = rrdy; v.e_rr = e_rr; v.e_mv = e_mv; v.e_mpa = e_mpa;
    v.e_rv = e_rv; v.e_rpa = e_rpa; v.e_err = e_err;
    tbl.push_back(v);
  endtask

  task automatic add_idle(input logic rr);
    add(O, O, Z29, O, O, Z28, O, Z28, O, rr, O, Z28, O, Z29, O);
  endtask

  task automatic add_push(input logic [28:0] pa);
    add(O, I, pa, O, O, Z28, O, Z28, O, I, O, Z28, O, Z29, O);
  endtask

  task automatic add_reset(input logic prev_rr);
    add(I, O, Z29, O, O, Z28, O, Z28, O, prev_rr, O, Z28, O, Z29, O);
    add(O, O, Z29, O, O, Z28, O, Z28, O, O, O, Z28, O, Z29, O);
  endtask

  // Head miss from IDLE: L2 read, response, demand fill (and sibling push when enabled).
  task automatic add_miss(input logic [28:0] pa, input logic rr);
    logic [27:0] p28;
    logic [28:0] sib;
    p28 = pa[28:1];
    sib = {pa[28:1], ~pa[0]};
    add_idle(rr);
    add(O, O, Z29, I, O, Z28, O, Z28, O, rr, I, p28, O, Z29, O);
    add(O, O, Z29, O, I, p28, O, Z28, O, rr, O, Z28, O, Z29, O);
    add(O, O, Z29, O, O, Z28, O, Z28, I, rr, O, Z28, I, pa, O);
`ifdef ICACHE_FILL_SIBLING_PUSH_EN
    add(O, O, Z29, O, O, Z28, O, Z28, I, rr, O, Z28, I, sib, O);
`endif
  endtask

  task automatic drive_vec(input vec_t v);
    rst               = v.rst;
    bus.req_valid     = v.rq;
    bus.req_PA29      = v.rpa;
    bus.mem_req_ready = v.mrdy;
    bus.mem_resp_valid = v.mrv;
    bus.mem_resp_PA28 = v.mrpa;
    bus.inv_valid     = v.iv;
    bus.inv_PA28      = v.ipa;
    bus.resp_ready    = v.rrdy;
  endtask

  task automatic check(input string name, input logic ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got rr=%0b mv=%0b mpa=%h rv=%0b rpa=%h err=%0b data=%h", name,
               bus.req_ready, bus.mem_req_valid, bus.mem_req_PA28, bus.resp_valid,
               bus.resp_PA29, bus.resp_err, bus.resp_data256[31:0]);
    end
  endtask

  initial begin
    vec_t        z;
    logic        ok;
    int          lat;
    int          n;
    int          exp_n;

    z = '{default: 1'b0};
    drive_vec(z);
    rst = 1'b1;

    // Single miss on the upper half of block 0x052.
    add(I, O, Z29, O, O, Z28, O, Z28, O, O, O, Z28, O, Z29, O);
    add(O, O, Z29, O, O, Z28, O, Z28, O, O, O, Z28, O, Z29, O);
    add_push(29'h00000A5);
    add_miss(29'h00000A5, I);
    add_idle(I);

    // Sibling hit: two requests to the same block, one L2 read.
    add_reset(I);
    add_push(29'h00000A4);
    add_push(29'h00000A5);
    add(O, O, Z29, I, O, Z28, O, Z28, O, I, I, 28'h0000052, O, Z29, O);
    add(O, O, Z29, O, I, 28'h0000052, O, Z28, O, I, O, Z28, O, Z29, O);
    add(O, O, Z29, O, O, Z28, O, Z28, I, I, O, Z28, I, 29'h00000A4, O);
`ifdef ICACHE_FILL_SIBLING_PUSH_EN
    add(O, O, Z29, O, O, Z28, O, Z28, I, I, O, Z28, I, 29'h00000A5, O);
`endif
    add_idle(I);
    add(O, O, Z29, O, O, Z28, O, Z28, I, I, O, Z28, I, 29'h00000A5, O);
`ifdef ICACHE_FILL_SIBLING_PUSH_EN
    add(O, O, Z29, O, O, Z28, O, Z28, I, I, O, Z28, I, 29'h00000A4, O);
`endif
    add_idle(I);
    add_idle(I);

    // Backpressure: four queued misses, L2 stalls 10 cycles, icache stalls 5 cycles.
    add_reset(I);
    add_push(29'h0000100);
    add_push(29'h0000103);
    add(O, I, 29'h0000104, O, O, Z28, O, Z28, O, I, I, 28'h0000080, O, Z29, O);
    add(O, I, 29'h0000107, O, O, Z28, O, Z28, O, I, I, 28'h0000080, O, Z29, O);
    add(O, I, 29'h00001FF, O, O, Z28, O, Z28, O, O, I, 28'h0000080, O, Z29, O);
    for (int k = 5; k < 12; k++) add(O, O, Z29, O, O, Z28, O, Z28, O, O, I, 28'h0000080, O, Z29, O);
    add(O, O, Z29, I, O, Z28, O, Z28, O, O, I, 28'h0000080, O, Z29, O);
    add(O, O, Z29, O, I, 28'h0000080, O, Z28, O, O, O, Z28, O, Z29, O);
    for (int k = 0; k < 5; k++) add(O, O, Z29, O, O, Z28, O, Z28, O, O, O, Z28, I, 29'h0000100, O);
    add(O, O, Z29, O, O, Z28, O, Z28, I, O, O, Z28, I, 29'h0000100, O);
`ifdef ICACHE_FILL_SIBLING_PUSH_EN
    add(O, O, Z29, O, O, Z28, O, Z28, I, I, O, Z28, I, 29'h0000101, O);
`endif
    add_miss(29'h0000103, I);
    add_miss(29'h0000104, I);
    add_miss(29'h0000107, I);
    add_idle(I);
    add_idle(I);

    // Invalidate while waiting: fill still returned, buffer not reused.
    add_reset(I);
    add_push(29'h00000A5);
    add_idle(I);
    add(O, O, Z29, I, O, Z28, O, Z28, O, I, I, 28'h0000052, O, Z29, O);
    add(O, O, Z29, O, O, Z28, I, 28'h0000052, O, I, O, Z28, O, Z29, O);
    add(O, O, Z29, O, I, 28'h0000052, O, Z28, O, I, O, Z28, O, Z29, O);
    add(O, O, Z29, O, O, Z28, O, Z28, I, I, O, Z28, I, 29'h00000A5, O);
    add_push(29'h00000A4);
    add_miss(29'h00000A4, I);
    add_idle(I);

    // Mismatched response sets the sticky error; reset clears it and ignores a stale response.
    add_reset(I);
    add_push(29'h00000A5);
    add_idle(I);
    add(O, O, Z29, I, O, Z28, O, Z28, O, I, I, 28'h0000052, O, Z29, O);
    add(O, O, Z29, O, I, 28'h0000053, O, Z28, O, I, O, Z28, O, Z29, O);
    add(O, O, Z29, O, I, 28'h0000052, O, Z28, O, I, O, Z28, O, Z29, I);
    add(I, O, Z29, O, O, Z28, O, Z28, O, I, O, Z28, I, 29'h00000A5, I);
    add(O, O, Z29, O, I, 28'h0000052, O, Z28, O, O, O, Z28, O, Z29, O);
    add_idle(I);
    add_idle(I);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", bus.req_ready === 1'b0 && bus.mem_req_valid === 1'b0 &&
          bus.mem_req_PA28 === 28'h0 && bus.resp_valid === 1'b0 && bus.resp_PA29 === 29'h0 &&
          bus.resp_data256 === 256'h0 && bus.resp_err === 1'b0);

    foreach (tbl[i]) begin
      @(negedge clk);
      ok = (bus.req_ready === tbl[i].e_rr) && (bus.mem_req_valid === tbl[i].e_mv) &&
           (!tbl[i].e_mv || bus.mem_req_PA28 === tbl[i].e_mpa) &&
           (bus.resp_valid === tbl[i].e_rv) &&
           (!tbl[i].e_rv || (bus.resp_PA29 === tbl[i].e_rpa &&
                             bus.resp_data256 === exp_half(tbl[i].e_rpa))) &&
           (bus.resp_err === tbl[i].e_err);
      if (!ok) $display("FAIL vec%0d: want rr=%0b mv=%0b mpa=%h rv=%0b rpa=%h err=%0b", i,
                        tbl[i].e_rr, tbl[i].e_mv, tbl[i].e_mpa, tbl[i].e_rv, tbl[i].e_rpa, tbl[i].e_err);
      check($sformatf("vec%0d", i), ok);
      drive_vec(tbl[i]);
    end

    // Hand sequence: miss latency to mem_req_valid and from mem_resp to resp_valid.
    @(negedge clk);
    drive_vec(z);
    bus.req_valid = 1'b1;
    bus.req_PA29  = 29'h00003C1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.mem_req_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("mem_req_latency", lat == 2 && bus.mem_req_valid === 1'b1 && bus.mem_req_PA28 === 28'h00001E0);
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_PA28  = 28'h00001E0;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    check("resp_latency", bus.resp_valid === 1'b1 && bus.mem_req_valid === 1'b0 &&
          bus.resp_PA29 === 29'h00003C1 && bus.resp_data256 === exp_half(29'h00003C1));
    bus.resp_ready = 1'b1;
`ifdef ICACHE_FILL_SIBLING_PUSH_EN
    exp_n = 2;
`else
    exp_n = 1;
`endif
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.resp_valid && n < 6);
    check("fill_drain", n == exp_n && bus.resp_valid === 1'b0 && bus.resp_err === 1'b0);
    bus.resp_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
